lsu: RTL and testbench

//   Load/store unit between the MIPS datapath and the word-port data memory
//   (combinational big-endian read, registered 32-bit write).

---
 rtl/lsu.sv | 177 +++++++++++++++++
 tb/tb_lsu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between the datapath and a word-port, big-endian data memory.
// Handles one request at a time; sub-word stores are done as read-modify-write.
//
// state   | meaning
// IDLE    | ready for a request; latches op/addr/wdata on req_valid
// LOAD    | memory read of the aligned word; lane extracted and extended
// READ    | memory read for SB/SH; store lane merged into wbuf
// WRITE   | wbuf written to the aligned word
// RESP    | response held until rsp_ready
module lsu #(
  parameter int unsigned MEMSIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_write,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic        store_q;
  logic [31:0] addr_q;
  logic [31:0] wbuf_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_store;
  logic        op_ok;
  logic        misaligned;
  logic        range_err;
  logic        req_err;
  logic [32:0] last_byte;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Request classification, evaluated on the incoming (not latched) request.
  always_comb begin
    req_store = req_op[3];
    op_ok     = 1'b0;
    if (req_store) begin
      op_ok = (req_op[2:0] == 3'b000) || (req_op[2:0] == 3'b001) ||
              (req_op[2:0] == 3'b011);
    end else begin
      op_ok = (req_op[2:0] == 3'b000) || (req_op[2:0] == 3'b001) ||
              (req_op[2:0] == 3'b011) || (req_op[2:0] == 3'b100) ||
              (req_op[2:0] == 3'b101);
    end
    misaligned = 1'b0;
    case (req_op[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b11:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap into range
    last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
    range_err = last_byte >= 33'(MEMSIZE);
    req_err   = !op_ok || misaligned || range_err;
  end

  // Big-endian lane extraction: byte offset 0 is the most significant byte.
  always_comb begin
    load_val = 32'h0;
    case (op_q)
      3'b000, 3'b100: begin
        case (addr_q[1:0])
          2'd0:    load_val = {24'h0, mem_rdata[31:24]};
          2'd1:    load_val = {24'h0, mem_rdata[23:16]};
          2'd2:    load_val = {24'h0, mem_rdata[15:8]};
          default: load_val = {24'h0, mem_rdata[7:0]};
        endcase
        if (!op_q[2]) load_val[31:8] = {24{load_val[7]}};
      end
      3'b001, 3'b101: begin
        load_val = addr_q[1] ? {16'h0, mem_rdata[15:0]} : {16'h0, mem_rdata[31:16]};
        if (!op_q[2]) load_val[31:16] = {16{load_val[15]}};
      end
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merge_val = mem_rdata;
    if (op_q[0]) begin
      if (addr_q[1]) merge_val[15:0]  = wbuf_q[15:0];
      else           merge_val[31:16] = wbuf_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_val[31:24] = wbuf_q[7:0];
        2'd1:    merge_val[23:16] = wbuf_q[7:0];
        2'd2:    merge_val[15:8]  = wbuf_q[7:0];
        default: merge_val[7:0]   = wbuf_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                          state_nxt = S_RESP;
          else if (!req_store)                  state_nxt = S_LOAD;
          else if (req_op[1:0] == 2'b11)        state_nxt = S_WRITE;
          else                                  state_nxt = S_READ;
        end
      end
      S_LOAD:  state_nxt = S_RESP;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= 3'b000;
      store_q <= 1'b0;
      addr_q  <= 32'h0;
      wbuf_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op[2:0];
            store_q <= req_op[3];
            addr_q  <= req_addr;
            wbuf_q  <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= req_err;
          end
        end
        S_LOAD:  rdata_q <= load_val;
        S_READ:  wbuf_q  <= merge_val;
        default: ;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = store_q ? 32'h0 : rdata_q;
  assign rsp_err   = err_q;
  assign mem_raddr = {addr_q[31:2], 2'b00};
  assign mem_waddr = {addr_q[31:2], 2'b00};
  assign mem_wdata = wbuf_q;
  // Gated by rst_n so a reset landing on the WRITE cycle suppresses the write.
  assign mem_write = (state == S_WRITE) && rst_n;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu with a 1 KiB big-endian word memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_write;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  lsu #(.MEMSIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_write(mem_write),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_raddr < 32'd1024) ? mem[mem_raddr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_waddr < 32'd1024) mem[mem_waddr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int writes);
    int w0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    writes = wr_cnt - w0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  logic [31:0] r;
  logic        e;
  int          l;
  int          w;
  int          w0;
  logic [31:0] held;

  initial begin
    //          op       addr          wdata          rdata          err  lat wr
    vt[0]  = '{4'b1011, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1};
    vt[1]  = '{4'b0011, 32'h0000_0010, 32'h0,        32'h1122_3344, 1'b0, 2, 0};
    vt[2]  = '{4'b1011, 32'h0000_0010, 32'h80FF_7F01, 32'h0000_0000, 1'b0, 2, 1};
    vt[3]  = '{4'b0000, 32'h0000_0010, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0};
    vt[4]  = '{4'b0100, 32'h0000_0010, 32'h0,        32'h0000_0080, 1'b0, 2, 0};
    vt[5]  = '{4'b0001, 32'h0000_0012, 32'h0,        32'h0000_7F01, 1'b0, 2, 0};
    vt[6]  = '{4'b0101, 32'h0000_0010, 32'h0,        32'h0000_80FF, 1'b0, 2, 0};
    vt[7]  = '{4'b0000, 32'h0000_0011, 32'h0,        32'hFFFF_FFFF, 1'b0, 2, 0};
    vt[8]  = '{4'b0000, 32'h0000_0013, 32'h0,        32'h0000_0001, 1'b0, 2, 0};
    vt[9]  = '{4'b0001, 32'h0000_0010, 32'h0,        32'hFFFF_80FF, 1'b0, 2, 0};
    vt[10] = '{4'b1011, 32'h0000_0020, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 2, 1};
    vt[11] = '{4'b1000, 32'h0000_0022, 32'h0000_0055, 32'h0000_0000, 1'b0, 3, 1};
    vt[12] = '{4'b0011, 32'h0000_0020, 32'h0,        32'hAABB_55DD, 1'b0, 2, 0};
    vt[13] = '{4'b1001, 32'h0000_0020, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 3, 1};
    vt[14] = '{4'b0011, 32'h0000_0020, 32'h0,        32'h1234_55DD, 1'b0, 2, 0};
    vt[15] = '{4'b0011, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1, 1, 0};
    vt[16] = '{4'b0001, 32'h0000_0013, 32'h0,        32'h0000_0000, 1'b1, 1, 0};
    vt[17] = '{4'b1011, 32'h0000_03FE, 32'hDEAD_0000, 32'h0000_0000, 1'b1, 1, 0};
    vt[18] = '{4'b0011, 32'h0000_0400, 32'h0,        32'h0000_0000, 1'b1, 1, 0};
    vt[19] = '{4'b0010, 32'h0000_0020, 32'h0,        32'h0000_0000, 1'b1, 1, 0};
    vt[20] = '{4'b1010, 32'h0000_0020, 32'h0,        32'h0000_0000, 1'b1, 1, 0};
    vt[21] = '{4'b1011, 32'h0000_03FC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1};
    vt[22] = '{4'b0000, 32'h0000_03FF, 32'h0,        32'hFFFF_FFEF, 1'b0, 2, 0};
    vt[23] = '{4'b0011, 32'h0000_0020, 32'h0,        32'h1234_55DD, 1'b0, 2, 0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset mem_write", {31'h0, mem_write}, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err",   {31'h0, rsp_err}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].op, vt[i].addr, vt[i].wdata, r, e, l, w);
      chk($sformatf("v%0d rdata", i), r, vt[i].rdata);
      chk($sformatf("v%0d err", i), {31'h0, e}, {31'h0, vt[i].err});
      chk($sformatf("v%0d latency", i), l, vt[i].lat);
      chk($sformatf("v%0d writes", i), w, vt[i].wr);
    end

    // Response held while rsp_ready stays low.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'b0011;
    req_addr  = 32'h0000_0020;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold valid start", {31'h0, rsp_valid}, 32'h1);
    held = rsp_rdata;
    chk("hold data", held, 32'h1234_55DD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold valid c%0d", i), {31'h0, rsp_valid}, 32'h1);
      chk($sformatf("hold rdata c%0d", i), rsp_rdata, 32'h1234_55DD);
      chk($sformatf("hold req_ready c%0d", i), {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("release req_ready", {31'h0, req_ready}, 32'h1);
    chk("release rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset landing on the READ cycle of an SB must suppress the write.
    do_req(4'b1011, 32'h0000_0030, 32'h0102_0304, r, e, l, w);
    chk("pre-reset store writes", w, 1);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'b1000;
    req_addr  = 32'h0000_0031;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset cycle mem_write", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("after reset mem_write", {31'h0, mem_write}, 32'h0);
    chk("after reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("after reset req_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("no write across reset", wr_cnt - w0, 0);
    do_req(4'b0011, 32'h0000_0030, 32'h0, r, e, l, w);
    chk("word after aborted SB", r, 32'h0102_0304);
    chk("word after aborted SB err", {31'h0, e}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
